// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud divisor and frame geometry.
package uart_pkg;

   localparam int unsigned BAUD_DIV_DEF = 2604;
   localparam int unsigned FRAME_BITS   = 10;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned SHREG_W      = DATA_W + 1;
   localparam int unsigned BAUD_CNT_W   = 12;
   localparam int unsigned BIT_CNT_W    = 4;
   localparam int unsigned BAUD_DIV_MAX = 4096;

   typedef enum logic {
      IDLE      = 1'b0,
      RECEIVING = 1'b1
   } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and acknowledge in, byte / ready / framing-error out.
interface uart_rx_if;
   import uart_pkg::*;

   logic              RX;
   logic              clr_rdy;
   logic [DATA_W-1:0] rx_data;
   logic              rdy;
   logic              frm_err;

   modport master (input RX, input clr_rdy, output rx_data, output rdy, output frm_err);
   modport slave  (output RX, output clr_rdy, input rx_data, input rdy, input frm_err);

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a start-edge-aligned baud counter,
// byte presented with a sticky ready flag and a framing-error flag.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.master bus
);

   localparam int unsigned HALF_DIV = BAUD_DIV / 2;

   if (BAUD_DIV > BAUD_DIV_MAX || BAUD_DIV < 4) begin : g_bad_baud_div
      $error("uart_rx: BAUD_DIV must lie in 4..4096 to fit the 12-bit baud counter");
   end

   rx_state_t              state_q;
   logic                   rx_meta_q;
   logic                   rx_s_q;
   logic                   rx_q;
   logic [BAUD_CNT_W-1:0]  baud_cnt_q;
   logic [BIT_CNT_W-1:0]   bit_cnt_q;
   logic [SHREG_W-1:0]     shreg_q;
   logic [SHREG_W-1:0]     shreg_d;
   logic [DATA_W-1:0]      rx_data_q;
   logic                   rdy_q;
   logic                   frm_err_q;
   logic                   start_edge;
   logic                   sample;
   logic                   start_bit_unused;

   assign start_edge = rx_q & ~rx_s_q;
   assign sample     = (state_q == RECEIVING) && (baud_cnt_q == '0);
   assign shreg_d    = {rx_s_q, shreg_q[SHREG_W-1:1]};

   // The start bit drops out of the bottom of the shifter and is never consumed.
   assign start_bit_unused = shreg_q[0];

   assign bus.rx_data = rx_data_q;
   assign bus.rdy     = rdy_q;
   assign bus.frm_err = frm_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_q       <= 1'b1;
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         rx_data_q  <= '0;
         rdy_q      <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         rx_meta_q <= bus.RX;
         rx_s_q    <= rx_meta_q;
         rx_q      <= rx_s_q;

         // Completion below overrides an acknowledge landing in the same cycle.
         if (bus.clr_rdy) begin
            rdy_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (start_edge) begin
                  state_q    <= RECEIVING;
                  baud_cnt_q <= BAUD_CNT_W'(HALF_DIV - 1);
                  bit_cnt_q  <= '0;
                  rdy_q      <= 1'b0;
               end
            end

            RECEIVING: begin
               if (sample) begin
                  shreg_q    <= shreg_d;
                  bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
                  baud_cnt_q <= BAUD_CNT_W'(BAUD_DIV - 1);
                  if ((bit_cnt_q == '0) && rx_s_q) begin
                     state_q <= IDLE;
                  end else if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                     state_q   <= IDLE;
                     rx_data_q <= shreg_d[DATA_W-1:0];
                     frm_err_q <= ~shreg_d[SHREG_W-1];
                     rdy_q     <= 1'b1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q - BAUD_CNT_W'(1);
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit, expected bytes queued on send
// and checked by a monitor on every rising edge of rdy.
module tb_uart_rx;

   localparam int unsigned BAUD = 32;
   localparam int unsigned HALF = BAUD / 2;
   localparam int unsigned LAT  = HALF + 9 * BAUD;

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          rises = 0;
   int          exp_rises = 0;
   int unsigned rise_cyc = 0;
   int unsigned start_cyc = 0;
   exp_t        sb_q[$];

   uart_rx_if bus();

   uart_rx #(.BAUD_DIV(BAUD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives the first nbits of a frame; only complete frames become expectations.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      if (nbits == 10) begin
         sb_q.push_back('{data: d, ferr: ~stop});
         exp_rises++;
      end
      for (int i = 0; i < nbits; i++) begin
         bus.RX = f[i];
         repeat (BAUD) @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      bus.RX = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.rdy === 1'b1 && prev !== 1'b1) begin
            rises++;
            rise_cyc = cyc;
            checks++;
            assert (sb_q.size() > 0) else begin
               errors++;
               $error("FAIL sb_unexpected_rdy observed=rise data=%0h expected=no_rise", bus.rx_data);
            end
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("sb_rx_data", 32'(bus.rx_data), 32'(e.data));
               chk("sb_frm_err", 32'(bus.frm_err), 32'(e.ferr));
            end
         end
         prev = bus.rdy;
      end
   end

   initial begin : stim
      int unsigned lat;
      rst         = 1'b1;
      bus.RX      = 1'b1;
      bus.clr_rdy = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_rx_data", 32'(bus.rx_data), 32'h00);
      chk("reset_rdy", 32'(bus.rdy), 32'h0);
      chk("reset_frm_err", 32'(bus.frm_err), 32'h0);
      rst = 1'b0;
      idle(2 * BAUD);
      chk("idle_rdy", 32'(bus.rdy), 32'h0);

      // Single frame with latency measured from the RX falling edge.
      start_cyc = cyc;
      send_frame(8'hA5, 1'b1, 10);
      idle(BAUD);
      chk("a5_rises", 32'(rises), 32'(exp_rises));
      lat = rise_cyc - start_cyc;
      checks++;
      assert (lat >= LAT + 2 && lat <= LAT + 4) else begin
         errors++;
         $error("FAIL a5_latency observed=%0d expected=%0d..%0d", lat, LAT + 2, LAT + 4);
      end
      chk("a5_rdy_sticky", 32'(bus.rdy), 32'h1);

      // Back-to-back frames, no acknowledge in between.
      send_frame(8'h00, 1'b1, 10);
      chk("b2b_first_data", 32'(bus.rx_data), 32'h00);
      chk("b2b_first_rdy", 32'(bus.rdy), 32'h1);
      fork
         send_frame(8'hFF, 1'b1, 10);
         begin
            repeat (6) @(negedge clk);
            chk("b2b_rdy_drop", 32'(bus.rdy), 32'h0);
         end
      join
      idle(BAUD);
      chk("b2b_second_data", 32'(bus.rx_data), 32'hFF);
      chk("b2b_second_rdy", 32'(bus.rdy), 32'h1);
      chk("b2b_rises", 32'(rises), 32'(exp_rises));

      // Acknowledge, then a short low glitch must abort without delivering anything.
      bus.clr_rdy = 1'b1;
      @(negedge clk);
      bus.clr_rdy = 1'b0;
      chk("clr_rdy", 32'(bus.rdy), 32'h0);
      bus.RX = 1'b0;
      repeat (BAUD / 4) @(negedge clk);
      idle(2 * BAUD);
      chk("glitch_rdy", 32'(bus.rdy), 32'h0);
      chk("glitch_rx_data", 32'(bus.rx_data), 32'hFF);
      chk("glitch_rises", 32'(rises), 32'(exp_rises));

      // Bad stop bit, then the line stays low: no retrigger.
      send_frame(8'h3C, 1'b0, 10);
      repeat (3 * BAUD) @(negedge clk);
      chk("bad_stop_frm_err", 32'(bus.frm_err), 32'h1);
      chk("stuck_low_rdy", 32'(bus.rdy), 32'h1);
      chk("stuck_low_rises", 32'(rises), 32'(exp_rises));
      idle(2 * BAUD);
      send_frame(8'h81, 1'b1, 10);
      idle(BAUD);
      chk("good_after_bad_frm_err", 32'(bus.frm_err), 32'h0);
      chk("good_after_bad_data", 32'(bus.rx_data), 32'h81);

      // Acknowledge on the completion cycle loses to the set; one cycle later it clears.
      start_cyc = cyc;
      fork
         send_frame(8'hC3, 1'b1, 10);
         begin
            repeat (LAT + 2) @(negedge clk);
            bus.clr_rdy = 1'b1;
            @(negedge clk);
            bus.clr_rdy = 1'b0;
            chk("clr_same_cycle_rdy", 32'(bus.rdy), 32'h1);
            bus.clr_rdy = 1'b1;
            @(negedge clk);
            bus.clr_rdy = 1'b0;
            chk("clr_next_cycle_rdy", 32'(bus.rdy), 32'h0);
         end
      join
      chk("clr_rises", 32'(rises), 32'(exp_rises));

      // Reset in the middle of a frame discards it.
      idle(BAUD);
      send_frame(8'h5A, 1'b1, 5);
      rst    = 1'b1;
      bus.RX = 1'b1;
      repeat (3) @(negedge clk);
      chk("midreset_rx_data", 32'(bus.rx_data), 32'h00);
      chk("midreset_rdy", 32'(bus.rdy), 32'h0);
      chk("midreset_frm_err", 32'(bus.frm_err), 32'h0);
      rst = 1'b0;
      idle(2 * BAUD);
      chk("postreset_rdy", 32'(bus.rdy), 32'h0);
      send_frame(8'h96, 1'b1, 10);
      idle(BAUD);
      chk("postreset_data", 32'(bus.rx_data), 32'h96);
      chk("postreset_rises", 32'(rises), 32'(exp_rises));

      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
